// File: rtl/div_iter_if.sv
// Handshake and operand/result bundle between the E-stage MDU control and the
// iterative divider.
//   master: pipeline side, drives start/flush/opcode/operands, receives results
//   slave : divider side
interface div_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic            FlushE;
    logic            DivStartE;
    logic [2:0]      Funct3E;
    logic            W64E;
    logic [XLEN-1:0] ForwardedSrcAE;
    logic [XLEN-1:0] ForwardedSrcBE;
    logic            DivBusyE;
    logic            DivDoneE;
    logic [XLEN-1:0] QuotE;
    logic [XLEN-1:0] RemE;

    modport master (
        output FlushE, DivStartE, Funct3E, W64E, ForwardedSrcAE, ForwardedSrcBE,
        input  DivBusyE, DivDoneE, QuotE, RemE
    );

    modport slave (
        input  FlushE, DivStartE, Funct3E, W64E, ForwardedSrcAE, ForwardedSrcBE,
        output DivBusyE, DivDoneE, QuotE, RemE
    );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU (and the
// W variants when XLEN=64). One quotient bit per cycle, then a sign fix-up
// cycle, then a one-cycle done pulse with quotient and remainder.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : div_iter_if slave (start/flush/opcode/operands in, busy/done/results out)
module div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic      clk,
    input  logic      reset,
    div_iter_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [XLEN-1:0] q_r, q_d;
    logic [XLEN-1:0] r_r, r_d;
    logic [XLEN-1:0] b_r, b_d;
    logic            w_r, w_d;
    logic            negq_r, negq_d;
    logic            negr_r, negr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;

    // Low-32 mask in word mode, all ones otherwise.
    function automatic logic [XLEN-1:0] width_mask(input logic w);
        width_mask = w ? XLEN'(32'hFFFF_FFFF) : '1;
    endfunction

    // Sign-extend bit 31 over the upper half in word mode.
    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x, input logic w);
        logic [XLEN-1:0] m;
        m      = width_mask(1'b1);
        sext_w = w ? ((x & m) | ({XLEN{x[31]}} & ~m)) : x;
    endfunction

    // Operand decode at the effective width.
    logic            w_in, sgn_in, a_neg, b_neg, b_zero, ovf;
    logic [XLEN-1:0] mask_in, msb_in, a_t, b_t, a_mag, b_mag, spc_q, spc_r;

    always_comb begin
        w_in    = (XLEN == 64) && bus.W64E;
        sgn_in  = ~bus.Funct3E[0];
        mask_in = width_mask(w_in);
        msb_in  = w_in ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        a_t     = bus.ForwardedSrcAE & mask_in;
        b_t     = bus.ForwardedSrcBE & mask_in;
        a_neg   = sgn_in && ((a_t & msb_in) != '0);
        b_neg   = sgn_in && ((b_t & msb_in) != '0);
        a_mag   = a_neg ? ((-a_t) & mask_in) : a_t;
        b_mag   = b_neg ? ((-b_t) & mask_in) : b_t;
        b_zero  = (b_t == '0);
        ovf     = sgn_in && (a_t == msb_in) && (b_t == mask_in);
        spc_q   = b_zero ? mask_in : a_t;
        spc_r   = b_zero ? a_t : '0;
    end

    // Opcode bits [2:1] only select DIV vs REM, and both results are produced.
    logic unused_in;
    assign unused_in = &{1'b0, bus.Funct3E[2:1], bus.W64E};

    // One restoring step: shift {rem, quot} left, trial-subtract the divisor.
    logic            shin;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] mask_r, qm, q_fix, r_fix;

    always_comb begin
        shin   = w_r ? q_r[31] : q_r[XLEN-1];
        rem_sh = {r_r, shin};
        diff   = rem_sh - {1'b0, b_r};
        mask_r = width_mask(w_r);
        qm     = q_r & mask_r;
        q_fix  = sext_w((negq_r ? -qm : qm) & mask_r, w_r);
        r_fix  = sext_w((negr_r ? -r_r : r_r) & mask_r, w_r);
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        q_d     = q_r;
        r_d     = r_r;
        b_d     = b_r;
        w_d     = w_r;
        negq_d  = negq_r;
        negr_d  = negr_r;
        quot_d  = quot_q;
        rem_d   = rem_q;

        unique case (state)
            IDLE: begin
                if (bus.DivStartE && !bus.FlushE) begin
                    w_d    = w_in;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    if (b_zero || ovf) begin
                        quot_d  = sext_w(spc_q, w_in);
                        rem_d   = sext_w(spc_r, w_in);
                        state_d = DONE;
                    end else begin
                        q_d     = a_mag;
                        r_d     = '0;
                        b_d     = b_mag;
                        cnt_d   = w_in ? CW'(32) : CW'(XLEN);
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (diff[XLEN]) begin
                    r_d = rem_sh[XLEN-1:0];
                    q_d = {q_r[XLEN-2:0], 1'b0};
                end else begin
                    r_d = diff[XLEN-1:0];
                    q_d = {q_r[XLEN-2:0], 1'b1};
                end
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = q_fix;
                rem_d   = r_fix;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush aborts from any state and never publishes results.
        if (bus.FlushE) begin
            state_d = IDLE;
            quot_d  = quot_q;
            rem_d   = rem_q;
        end
    end

    assign busy_d = (state_d != IDLE);
    assign done_d = (state_d == DONE);

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            q_r    <= '0;
            r_r    <= '0;
            b_r    <= '0;
            w_r    <= 1'b0;
            negq_r <= 1'b0;
            negr_r <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            q_r    <= q_d;
            r_r    <= r_d;
            b_r    <= b_d;
            w_r    <= w_d;
            negq_r <= negq_d;
            negr_r <= negr_d;
            busy_q <= busy_d;
            done_q <= done_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
        end
    end

    assign bus.DivBusyE = busy_q;
    assign bus.DivDoneE = done_q;
    assign bus.QuotE    = quot_q;
    assign bus.RemE     = rem_q;
endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: one XLEN=32 and one XLEN=64 instance on a
// shared clock and reset.
module tb_div_iter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    div_iter_if #(.XLEN(32)) b32 ();
    div_iter_if #(.XLEN(64)) b64 ();

    div_iter #(.XLEN(32)) u32 (.clk(clk), .reset(reset), .bus(b32));
    div_iter #(.XLEN(64)) u64 (.clk(clk), .reset(reset), .bus(b64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rd_done(input bit sel);
        return sel ? b64.DivDoneE : b32.DivDoneE;
    endfunction

    function automatic logic rd_busy(input bit sel);
        return sel ? b64.DivBusyE : b32.DivBusyE;
    endfunction

    function automatic logic [63:0] rd_quot(input bit sel);
        return sel ? b64.QuotE : 64'(b32.QuotE);
    endfunction

    function automatic logic [63:0] rd_rem(input bit sel);
        return sel ? b64.RemE : 64'(b32.RemE);
    endfunction

    task automatic set_in(input bit sel, input logic start, input logic flush,
                          input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
        if (sel) begin
            b64.DivStartE = start; b64.FlushE = flush; b64.Funct3E = f3;
            b64.W64E = w; b64.ForwardedSrcAE = a; b64.ForwardedSrcBE = b;
        end else begin
            b32.DivStartE = start; b32.FlushE = flush; b32.Funct3E = f3;
            b32.W64E = w; b32.ForwardedSrcAE = a[31:0]; b32.ForwardedSrcBE = b[31:0];
        end
    endtask

    task automatic release_start(input bit sel);
        if (sel) b64.DivStartE = 1'b0;
        else     b32.DivStartE = 1'b0;
    endtask

    // lat counts cycles after the start cycle; bounded at 200.
    task automatic wait_done(input bit sel, input int lat0, output int lat, output int busy);
        lat  = lat0;
        busy = 0;
        while (1) begin
            if (rd_busy(sel)) busy++;
            if (rd_done(sel) || lat >= 200) break;
            tick();
            lat++;
        end
    endtask

    task automatic op(input bit sel, input string tag, input logic [2:0] f3, input logic w,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] qx, input logic [63:0] rx, input int latx);
        int lat, busy;
        set_in(sel, 1'b1, 1'b0, f3, w, a, b);
        tick();
        release_start(sel);
        wait_done(sel, 1, lat, busy);
        chk({tag, "_done"}, 64'(rd_done(sel)), 64'd1);
        chk({tag, "_q"}, rd_quot(sel), qx);
        chk({tag, "_r"}, rd_rem(sel), rx);
        chk({tag, "_lat"}, 64'(lat), 64'(latx));
        chk({tag, "_busycyc"}, 64'(busy), 64'(latx));
        tick();
        chk({tag, "_pulse"}, 64'(rd_done(sel)), 64'd0);
        chk({tag, "_idle"}, 64'(rd_busy(sel)), 64'd0);
    endtask

    initial begin
        int  lat, busy;
        bit  seen;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0, 64'd0);
        set_in(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0, 64'd0);
        #12;
        chk("rst32_busy", 64'(b32.DivBusyE), 64'd0);
        chk("rst32_done", 64'(b32.DivDoneE), 64'd0);
        chk("rst32_q", 64'(b32.QuotE), 64'd0);
        chk("rst32_r", 64'(b32.RemE), 64'd0);
        chk("rst64_busy", 64'(b64.DivBusyE), 64'd0);
        chk("rst64_q", b64.QuotE, 64'd0);
        reset = 1'b1;
        tick();

        // 32-bit normal path, back-to-back starts
        op(1'b0, "div_m7_2", F_DIV, 1'b0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 64'hFFFF_FFFF, 34);
        op(1'b0, "divu_big", F_DIVU, 1'b0, 64'hFFFF_FFFF, 64'h10, 64'h0FFF_FFFF, 64'hF, 34);
        op(1'b0, "remu_5_7", F_REMU, 1'b0, 64'd5, 64'd7, 64'd0, 64'd5, 34);

        // 32-bit special cases and unsigned near-overflow
        op(1'b0, "div_by0", F_DIV, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF, 64'h1234, 1);
        op(1'b0, "divu_min_m1", F_DIVU, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 64'h8000_0000, 34);
        op(1'b0, "div_ovf", F_DIV, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 64'd0, 1);

        // 64-bit instance: word ops, full-width op, word divide-by-zero
        op(1'b1, "divw_m7_2", F_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        op(1'b1, "divuw_sext", F_DIVU, 1'b1, 64'h8000_0000, 64'd1,
           64'hFFFF_FFFF_8000_0000, 64'd0, 34);
        op(1'b1, "remw_hi_junk", F_REM, 1'b1, 64'h1234_5678_0000_0064, 64'hFFFF_FFFF_FFFF_FFF9,
           64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 34);
        op(1'b1, "div64_m7_2", F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        op(1'b1, "divuw_by0", F_DIVU, 1'b1, 64'd5, 64'hABCD_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);

        // Flush in DIV cycle 10: abort, no done, results held
        set_in(1'b0, 1'b1, 1'b0, F_DIV, 1'b0, 64'd100, 64'd7);
        tick();
        release_start(1'b0);
        repeat (9) tick();
        chk("fl_busy_before", 64'(b32.DivBusyE), 64'd1);
        b32.FlushE = 1'b1;
        tick();
        b32.FlushE = 1'b0;
        chk("fl_busy", 64'(b32.DivBusyE), 64'd0);
        chk("fl_done", 64'(b32.DivDoneE), 64'd0);
        chk("fl_q_held", 64'(b32.QuotE), 64'h8000_0000);
        chk("fl_r_held", 64'(b32.RemE), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (b32.DivDoneE) seen = 1'b1;
        end
        chk("fl_never_done", 64'(seen), 64'd0);

        // Flush and start together in IDLE: nothing starts
        set_in(1'b0, 1'b1, 1'b1, F_DIV, 1'b0, 64'd100, 64'd7);
        tick();
        set_in(1'b0, 1'b0, 1'b0, F_DIV, 1'b0, 64'd100, 64'd7);
        chk("flst_busy", 64'(b32.DivBusyE), 64'd0);
        tick();
        chk("flst_busy2", 64'(b32.DivBusyE), 64'd0);

        // Start held into the busy cycle with new operands: ignored
        set_in(1'b0, 1'b1, 1'b0, F_DIV, 1'b0, 64'd100, 64'd7);
        tick();
        set_in(1'b0, 1'b1, 1'b0, F_DIV, 1'b0, 64'd1, 64'd1);
        tick();
        release_start(1'b0);
        wait_done(1'b0, 2, lat, busy);
        chk("ign_q", 64'(b32.QuotE), 64'd14);
        chk("ign_r", 64'(b32.RemE), 64'd2);
        chk("ign_lat", 64'(lat), 64'd34);
        tick();

        // Asynchronous reset mid-DIV
        set_in(1'b0, 1'b1, 1'b0, F_DIV, 1'b0, 64'd1000, 64'd3);
        tick();
        release_start(1'b0);
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", 64'(b32.DivBusyE), 64'd0);
        chk("arst_done", 64'(b32.DivDoneE), 64'd0);
        chk("arst_q", 64'(b32.QuotE), 64'd0);
        chk("arst_r", 64'(b32.RemE), 64'd0);
        #2;
        reset = 1'b1;
        tick();
        op(1'b0, "post_rst", F_DIV, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring integer divider for the MDU; the inverse of the pipelined multiplier.
- Executes RISC-V DIV/DIVU/REM/REMU, and the W variants when XLEN=64.
- Takes forwarded E-stage operands, holds the pipeline busy for the iteration count, and delivers quotient and remainder together with a one-cycle done pulse.

Parameters:
XLEN, 32, datapath width; 32 or 64 only.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
FlushE  input  1  synchronous abort of any operation in progress
DivStartE  input  1  start request; sampled only in IDLE
Funct3E  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; bit0 = unsigned
W64E  input  1  word op (32-bit operands, sign-extended result); ignored when XLEN=32
ForwardedSrcAE  input  XLEN  dividend
ForwardedSrcBE  input  XLEN  divisor
DivBusyE  output  1  high whenever state is not IDLE
DivDoneE  output  1  one-cycle pulse; results valid this cycle
QuotE  output  XLEN  quotient; held until the next accepted start
RemE  output  XLEN  remainder; held until the next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, DivBusyE=0, DivDoneE=0, QuotE=0, RemE=0.
- States: IDLE, DIV, FIX, DONE.
- Start acceptance: in IDLE with DivStartE=1 and FlushE=0, capture operands, Funct3E[0] and W64E (W only if XLEN=64). Operand changes after capture have no effect.
- Effective width N: 32 if W, else XLEN. In W mode the operands are the low 32 bits; signed ops use two's-complement values at width N.
- Special cases are decided at start and go IDLE->DONE, so DivDoneE is asserted 1 cycle after the start cycle:
  - Divisor=0: Q = all ones, R = dividend.
  - Signed op with dividend = most-negative and divisor = -1: Q = dividend, R = 0.
- Normal path, IDLE->DIV:
  - Load the magnitudes |A| and |B| (raw values if unsigned); remainder accumulator = 0; counter = N.
  - Each DIV cycle: shift {rem, quot} left by 1; trial-subtract divisor from rem; if the result is non-negative, keep it and set quot LSB = 1; decrement counter.
  - When counter reaches 0, go DIV->FIX.
- FIX: negate Q if signed and the operand signs differ; negate R if signed and the dividend is negative. Then FIX->DONE.
- Normal latency: start sampled in cycle k; DivDoneE high in cycle k+N+2.
- DONE: DivDoneE=1 for exactly one cycle; QuotE/RemE updated at entry to DONE; then DONE->IDLE.
- Result width in W mode: the 32-bit result is sign-extended to 64 for all four ops, including DIVUW/REMUW, per RISC-V.
- DivBusyE is high in DIV, FIX and DONE, and low in IDLE.
- DivStartE while not in IDLE: ignored; no queuing.
- FlushE=1 in any state: next state is IDLE and DivDoneE is not asserted. QuotE/RemE keep their prior values.
- FlushE and DivStartE together in IDLE: flush wins and nothing starts.
- Reset asserted mid-operation: immediate return to the reset values.
- A start in the cycle right after DONE (back in IDLE) is legal and accepted.

Test Plan:
- XLEN=32, DIV A=0xFFFFFFF9 (-7), B=2 -> QuotE=0xFFFFFFFD, RemE=0xFFFFFFFF; DivDoneE exactly 34 cycles after the start cycle; DivBusyE high for 34 cycles.
- XLEN=32, DIVU A=0xFFFFFFFF, B=0x10 -> QuotE=0x0FFFFFFF, RemE=0xF. Then immediately REMU A=5, B=7 -> RemE=5, QuotE=0.
- XLEN=32, DIV A=0x1234, B=0 -> QuotE=0xFFFFFFFF, RemE=0x1234, done 1 cycle after start. Also DIV A=0x80000000, B=0xFFFFFFFF -> QuotE=0x80000000, RemE=0, done 1 cycle after start.
- XLEN=64, W64E=1, DIV A=0x00000000_FFFFFFF9, B=2 -> QuotE=0xFFFFFFFF_FFFFFFFD, done at +34. Also DIVU (W) A=0x80000000, B=1 -> QuotE=0xFFFFFFFF_80000000.
- Start a DIV, assert FlushE in DIV cycle 10 -> DivBusyE=0 the next cycle, no DivDoneE, outputs unchanged. A new start then completes correctly. Also assert DivStartE while busy -> ignored.
- Drive reset=0 asynchronously mid-DIV -> outputs go to 0 without a clock edge. After release, a fresh DIV 100/7 -> QuotE=14, RemE=2.
